// File: rtl/prog_loader.sv
// prog_loader: serial program loader and unified memory for the HMMM core.
//
// A 25-bit serial frame {cmd[1:0], adr[7:0], data[14:0]} (MSB first, sampled
// on synchronized sck rises while cs_n is low) halts or releases the core, or
// writes a memory word while the core is halted. The core reads the memory
// combinationally and may store bytes into it while running.
//
// Build option: define PROG_LOADER_READBACK_EN to enable the READ command,
// which shifts mem[adr] out on sdo. Without it sdo is tied low and READ is a
// no-op.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   sck, cs_n, sdi    serial clock, frame select (active-low), data in
//   sdo               serial readback data
//   cpu_adr           processor address
//   cpu_memwrite      processor store strobe (honoured only while running)
//   cpu_wdata         processor store byte, zero-extended into memory
//   cpu_rdata         mem[cpu_adr], combinational
//   cpu_reset         active-high core reset (= ~running)
//   running           core released
//   err               sticky: WRITE frame rejected because core was running
module prog_loader #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              sdi,
  output logic              sdo,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic              cpu_memwrite,
  input  logic [7:0]        cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_reset,
  output logic              running,
  output logic              err
);

  localparam int unsigned FRAME_W = 25;

  typedef enum logic [1:0] {IDLE, SHIFT, EXEC, WAIT} state_e;
  typedef enum logic [1:0] {
    CMD_HALT  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RUN   = 2'b11
  } cmd_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, sdi_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      sdi_sync_q <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, sdi_s;
  logic sck_rise_d, sck_fall_d, cs_fall_d, cs_rise_d;

  always_comb begin
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    cs_s       = cs_sync_q[SYNC_STAGES-1];
    sdi_s      = sdi_sync_q[SYNC_STAGES-1];
    sck_rise_d = sck_s & ~sck_prev_q;
    sck_fall_d = ~sck_s & sck_prev_q;
    cs_fall_d  = ~cs_s & cs_prev_q;
    cs_rise_d  = cs_s & ~cs_prev_q;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [4:0]          cnt_q;
  logic [FRAME_W-1:0]  shift_q;
  logic                running_q, err_q;

  cmd_e                frame_cmd;
  logic [ADDR_W-1:0]   frame_adr;
  logic [DATA_W-1:0]   frame_data;

  always_comb begin
    frame_cmd  = cmd_e'(shift_q[24:23]);
    frame_adr  = ADDR_W'(shift_q[22:15]);
    frame_data = DATA_W'(shift_q[14:0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      running_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall_d) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          if (cs_rise_d) begin
            state_q <= IDLE;
          end else if (sck_rise_d) begin
            shift_q <= {shift_q[FRAME_W-2:0], sdi_s};
            cnt_q   <= cnt_q + 5'd1;
            if (cnt_q == 5'(FRAME_W - 1)) state_q <= EXEC;
          end
        end
        EXEC: begin
          case (frame_cmd)
            CMD_HALT:  running_q <= 1'b0;
            CMD_WRITE: if (running_q) err_q <= 1'b1;
            CMD_RUN:   running_q <= 1'b1;
            default:   ;
          endcase
          state_q <= WAIT;
        end
        // Level test rather than edge: a cs_n rise landing on the EXEC cycle
        // must still return the FSM to IDLE.
        WAIT: begin
          if (cs_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory: loader writes only while halted, CPU stores only while running,
  // so the two write ports are mutually exclusive.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              loader_we_d, cpu_we_d;

  always_comb begin
    loader_we_d = (state_q == EXEC) && (frame_cmd == CMD_WRITE) && !running_q;
    cpu_we_d    = running_q && cpu_memwrite;
  end

  always_ff @(posedge clk) begin
    if (loader_we_d)   mem[frame_adr] <= frame_data;
    else if (cpu_we_d) mem[cpu_adr]   <= DATA_W'(cpu_wdata);
  end

  assign cpu_rdata = mem[cpu_adr];
  assign running   = running_q;
  assign cpu_reset = ~running_q;
  assign err       = err_q;

  // ---------------------------------------------------------------------------
  // Readback
  // ---------------------------------------------------------------------------
`ifdef PROG_LOADER_READBACK_EN
  logic [DATA_W-1:0] rb_q;

  // After 10 bits the command and address sit in shift_q[9:0]; the word is
  // loaded on the following sck fall and then shifted out MSB first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_q <= '0;
    end else if (state_q == IDLE && cs_fall_d) begin
      rb_q <= '0;
    end else if (state_q == SHIFT && sck_fall_d) begin
      if (cnt_q == 5'd10 && cmd_e'(shift_q[9:8]) == CMD_READ)
        rb_q <= mem[ADDR_W'(shift_q[7:0])];
      else if (cnt_q > 5'd10)
        rb_q <= {rb_q[DATA_W-2:0], 1'b0};
    end
  end

  assign sdo = rb_q[DATA_W-1];
`else
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset, sck, cs_n, sdi, sdo;
  logic [7:0]  cpu_adr, cpu_wdata;
  logic        cpu_memwrite;
  logic [14:0] cpu_rdata;
  logic        cpu_reset, running, err;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .DATA_W(15), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .sck          (sck),
    .cs_n         (cs_n),
    .sdi          (sdi),
    .sdo          (sdo),
    .cpu_adr      (cpu_adr),
    .cpu_memwrite (cpu_memwrite),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_reset    (cpu_reset),
    .running      (running),
    .err          (err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    string       tag;
    logic [7:0]  adr;
    logic [14:0] val;
  } exp_t;

  exp_t sb_q[$];

  logic [14:0] rb_word;
  logic        run_at3, run_at4, crst_at4;
  logic [14:0] rdata_at4;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_push(input string tag, input logic [7:0] adr, input logic [14:0] val);
    exp_t e;
    e.tag = tag;
    e.adr = adr;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cpu_adr = e.adr;
      clk_n(1);
      check_eq(e.tag, {17'b0, cpu_rdata}, {17'b0, e.val});
    end
  endtask

  // Sends the first nbits of a frame; sdo is captured just before rises
  // 11..25 and outputs are captured 3 and 4 clk rises after the 25th rise.
  task automatic send_frame(input logic [1:0] cmd, input logic [7:0] adr,
                            input logic [14:0] data, input int nbits);
    logic [24:0] fr;
    fr      = {cmd, adr, data};
    rb_word = '0;
    cs_n    = 1'b0;
    clk_n(6);
    for (int p = 1; p <= nbits; p++) begin
      sdi = fr[25-p];
      clk_n(6);
      if (p >= 11) rb_word[25-p] = sdo;
      sck = 1'b1;
      if (p == 25) begin
        clk_n(3);
        run_at3 = running;
        clk_n(1);
        run_at4   = running;
        crst_at4  = cpu_reset;
        rdata_at4 = cpu_rdata;
        clk_n(3);
      end else begin
        clk_n(6);
      end
      sck = 1'b0;
    end
    clk_n(6);
    cs_n = 1'b1;
    clk_n(6);
  endtask

  initial begin
    reset        = 1'b0;
    sck          = 1'b0;
    cs_n         = 1'b1;
    sdi          = 1'b0;
    cpu_adr      = 8'h05;
    cpu_memwrite = 1'b0;
    cpu_wdata    = 8'h00;
    clk_n(3);
    reset = 1'b1;
    clk_n(3);

    check_eq("rst_cpu_reset", cpu_reset, 1);
    check_eq("rst_running", running, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_sdo", sdo, 0);

    // Loader writes while halted
    cpu_adr = 8'h05;
    send_frame(2'b01, 8'h05, 15'h1A2B, 25);
    check_eq("wr05_at_edge4", {17'b0, rdata_at4}, 32'h1A2B);
    check_eq("wr05_still_halted", run_at4, 0);
    sb_push("wr05", 8'h05, 15'h1A2B);
    send_frame(2'b01, 8'hFF, 15'h7FFF, 25);
    sb_push("wrFF", 8'hFF, 15'h7FFF);
    send_frame(2'b01, 8'h00, 15'h0000, 25);
    sb_push("wr00", 8'h00, 15'h0000);
    send_frame(2'b01, 8'h40, 15'h5555, 25);
    sb_push("wr40", 8'h40, 15'h5555);
    send_frame(2'b01, 8'h20, 15'h2AAA, 25);
    sb_push("wr20", 8'h20, 15'h2AAA);
    sb_drain();

    // Readback while halted
    send_frame(2'b10, 8'h05, 15'h0000, 25);
`ifdef PROG_LOADER_READBACK_EN
    check_eq("rd05_sdo", {17'b0, rb_word}, 32'h1A2B);
`else
    check_eq("rd05_sdo", {17'b0, rb_word}, 32'h0);
`endif
    check_eq("rd05_no_err", err, 0);
    check_eq("rd05_halted", running, 0);

    // RUN
    send_frame(2'b11, 8'h00, 15'h0000, 25);
    check_eq("run_edge3", run_at3, 0);
    check_eq("run_edge4", run_at4, 1);
    check_eq("run_cpu_reset", crst_at4, 0);

    // CPU store while running
    cpu_adr      = 8'h40;
    cpu_wdata    = 8'h7E;
    cpu_memwrite = 1'b1;
    clk_n(1);
    cpu_memwrite = 1'b0;
    sb_push("cpu_st40", 8'h40, 15'h007E);
    sb_drain();

    // Loader WRITE while running is rejected
    send_frame(2'b01, 8'h40, 15'h1234, 25);
    check_eq("wr_running_err", err, 1);
    sb_push("wr40_blocked", 8'h40, 15'h007E);
    sb_drain();

    // Readback while running
    send_frame(2'b10, 8'h40, 15'h0000, 25);
`ifdef PROG_LOADER_READBACK_EN
    check_eq("rd40_sdo", {17'b0, rb_word}, 32'h007E);
`else
    check_eq("rd40_sdo", {17'b0, rb_word}, 32'h0);
`endif
    check_eq("rd40_running", running, 1);

    // HALT
    send_frame(2'b00, 8'h00, 15'h0000, 25);
    check_eq("halt_edge3", run_at3, 1);
    check_eq("halt_edge4", run_at4, 0);
    check_eq("halt_cpu_reset", crst_at4, 1);

    // CPU store while halted is ignored
    cpu_adr      = 8'h20;
    cpu_wdata    = 8'h99;
    cpu_memwrite = 1'b1;
    clk_n(1);
    cpu_memwrite = 1'b0;
    sb_push("cpu_st20_ignored", 8'h20, 15'h2AAA);

    // Aborted frame followed by a full frame
    send_frame(2'b01, 8'h10, 15'h3333, 12);
    send_frame(2'b01, 8'h10, 15'h0001, 25);
    sb_push("abort_then_wr10", 8'h10, 15'h0001);
    check_eq("err_sticky", err, 1);
    sb_drain();

    // Reset mid-frame: partial RUN frame discarded, err cleared, memory kept
    cs_n = 1'b0;
    clk_n(6);
    for (int p = 1; p <= 15; p++) begin
      sdi = (p <= 2);
      clk_n(6);
      sck = 1'b1;
      clk_n(6);
      sck = 1'b0;
    end
    reset = 1'b0;
    clk_n(2);
    cs_n  = 1'b1;
    clk_n(2);
    reset = 1'b1;
    clk_n(6);
    check_eq("midrst_err", err, 0);
    check_eq("midrst_running", running, 0);
    send_frame(2'b01, 8'h11, 15'h0ABC, 25);
    sb_push("post_rst_wr11", 8'h11, 15'h0ABC);
    sb_push("mem_kept05", 8'h05, 15'h1A2B);
    sb_push("mem_kept10", 8'h10, 15'h0001);
    sb_drain();
    check_eq("post_rst_halted", running, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and unified 256×15 memory for the HMMM core. The block sits directly downstream of the processor's memory port and supplies its `Adr`/`MemData` traffic. It also accepts a slow serial command stream from off-chip. It holds the core in reset while a program is written in, then releases it, and can halt it again later.

## Interface
- `ADDR_W`, default 8: memory address width; memory depth is 2^ADDR_W.
- `DATA_W`, default 15: memory word width; equals the instruction width.
- `SYNC_STAGES`, default 2: synchronizer depth on `sck`, `cs_n`, `sdi`.
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-low reset.
- `sck` input 1: serial clock, asynchronous to `clk`.
- `cs_n` input 1: serial frame select, active-low.
- `sdi` input 1: serial data in, MSB first.
- `sdo` output 1: serial readback data; see Configuration.
- `cpu_adr` input ADDR_W: processor `Adr`.
- `cpu_memwrite` input 1: processor `MemWrite`.
- `cpu_wdata` input 8: processor store data, `MemData[7:0]` when writing.
- `cpu_rdata` output DATA_W: word at `cpu_adr`, driven onto processor `ReadData`.
- `cpu_reset` output 1: active-high reset to the core.
- `running` output 1: core released.
- `err` output 1: sticky flag for a rejected serial write.

## Operation
- Frame format: 25 bits. `cmd[1:0]`, then `adr[7:0]`, then `data[14:0]`. All fields MSB first, sampled on synchronized `sck` rising edges while `cs_n` is low.
- Commands:
  - 00 HALT: clear `running`.
  - 01 WRITE: write `mem[adr] <= data`, only while halted. A WRITE while running does not touch memory and sets `err`.
  - 10 READ: readback, only with the macro compiled in.
  - 11 RUN: set `running`.
- FSM states: IDLE, SHIFT, EXEC, WAIT.
  - IDLE → SHIFT when synchronized `cs_n` falls. The bit counter clears to 0.
  - SHIFT: each detected `sck` rise shifts `sdi` into a 25-bit shift register and increments a 5-bit counter. Counter reaching 25 → EXEC.
  - EXEC: lasts exactly one clk. The command is applied, then the FSM moves to WAIT.
  - WAIT: further `sck` edges are ignored until `cs_n` rises, then → IDLE.
- Aborted frame: `cs_n` rising in SHIFT before 25 bits → IDLE with no effect, no `err`.
- `cpu_reset` = ~`running`.
- `cpu_rdata` = `mem[cpu_adr]`, combinational, with no reset value. Memory contents are not cleared by reset.
- CPU store: on clk rise with `running`=1 and `cpu_memwrite`=1, `mem[cpu_adr] <= {7'b0, cpu_wdata}`.
- CPU stores while halted are ignored. Loader writes and CPU writes therefore never collide.
- `err` clears only on `reset`.

## Timing
- Reset values: `running`=0, `cpu_reset`=1, `sdo`=0, `err`=0, FSM=IDLE, counter=0.
- Reset asserted mid-frame discards the partial frame.
- Serial inputs pass through SYNC_STAGES flops. Edges are detected by comparing against the previous synchronized sample.
- `sck` high and low times must each be ≥ SYNC_STAGES+1 clk periods.
- With SYNC_STAGES=2, the EXEC cycle occurs on the 4th clk rise after the 25th `sck` rise at the pin.
  - WRITE: visible on `cpu_rdata` after that edge.
  - RUN/HALT: `running` and `cpu_reset` change on that same edge.
- A CPU write and `cpu_rdata` for the same address: the new value appears after the write edge. Reads are combinational, so the core's instruction flop captures it on the following cycle.
- HALT during a CPU store cycle: a store sampled on the EXEC edge itself still commits. `running` falls on that same edge.

## Configuration
- `PROG_LOADER_READBACK_EN` defined:
  - READ loads `mem[adr]` into a 15-bit output register on the first `sck` fall after the 10th rise. `sdo` = register bit 14.
  - Each later `sck` fall shifts the register left, so the master samples data bits 14..0 on rises 11..25.
  - READ is legal while running.
- Macro undefined:
  - `sdo` is tied 0.
  - READ behaves as a no-op and does not set `err`.

## Test plan
- Reset, then no frames → `cpu_reset`=1, `running`=0, `err`=0, `sdo`=0.
- While halted, WRITE adr 0x05 data 0x1A2B, then `cpu_adr`=0x05 → `cpu_rdata`=0x1A2B within 4 clk of the 25th `sck` rise.
- RUN frame → `cpu_reset` falls. The core stores 0x7E at 0x40 → `cpu_rdata`@0x40 = 0x007E. A following WRITE frame to 0x40 leaves it 0x007E and sets `err`=1.
- Frame aborted after 12 bits, then a full WRITE adr 0x10 data 0x0001 → only the second frame takes effect; 0x10 holds 0x0001.
- HALT while running → `cpu_reset`=1. A `cpu_memwrite` pulse at 0x20 afterwards leaves `mem[0x20]` unchanged.
- Readback, macro defined: READ adr 0x05 after the first WRITE → `sdo` yields 0x1A2B on rises 11..25. With the macro undefined, `sdo` stays 0.
